pipe_addsub: RTL



---
 rtl/pipe_addsub_pkg.sv | 20 ++
 rtl/cla_slice.sv | 38 +++
 rtl/pipe_addsub.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pipe_addsub_pkg.sv
// Shared encodings and helpers for the pipelined add/subtract unit.
package pipe_addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBB = 2'b11
    } op_e;

    localparam int unsigned FLAG_N = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;

    function automatic int unsigned stages_f(input int unsigned width, input int unsigned slice);
        return width / slice;
    endfunction

endpackage

// File: rtl/cla_slice.sv
// SLICE-bit combinational carry-lookahead adder; c_msb is the carry into the top bit.
module cla_slice #(
    parameter int unsigned SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is expanded independently from ci so no carry feeds another.
    always_comb begin
        logic acc;
        c    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < SLICE; i++) begin
            acc = ci;
            for (int unsigned j = 0; j <= i; j++) begin
                acc = g[j] | (p[j] & acc);
            end
            c[i+1] = acc;
        end
    end

    assign s     = p ^ c[SLICE-1:0];
    assign co    = c[SLICE];
    assign c_msb = c[SLICE-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract with valid/ready handshake, one slice per stage.
// Optional saturation enabled by defining PIPE_ADDSUB_SAT_EN.
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
`ifdef PIPE_ADDSUB_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             neg
);

    localparam int unsigned STAGES = stages_f(WIDTH, SLICE);
    localparam int unsigned L      = STAGES - 1;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    logic [STAGES-1:0][WIDTH-1:0] opa, opb, rin;
    logic [STAGES-1:0][WIDTH-1:0] ska_d, ska_q, skb_d, skb_q, res_d, res_q;
    logic [STAGES-1:0][SLICE-1:0] ss;
    logic [STAGES-1:0]            ci, co, cm, zin, vin;
    logic [STAGES-1:0]            c_d, c_q, z_d, z_q, v_d, v_q;
    logic                         ovf_d, ovf_q;
`ifdef PIPE_ADDSUB_SAT_EN
    logic [STAGES-1:0]            satin, sain, sat_d, sat_q, sa_d, sa_q;
`endif

    always_comb begin
        b_eff   = b;
        cin_eff = 1'b0;
        case (op_e'(op))
            OP_ADD: begin b_eff = b;  cin_eff = 1'b0; end
            OP_SUB: begin b_eff = ~b; cin_eff = 1'b1; end
            OP_ADC: begin b_eff = b;  cin_eff = cin;  end
            OP_SBB: begin b_eff = ~b; cin_eff = cin;  end
            default: ;
        endcase
    end

    // Stage 0 takes operands straight from the ports; later stages from the skew registers.
    always_comb begin
        opa[0] = a;
        opb[0] = b_eff;
        ci[0]  = cin_eff;
        rin[0] = '0;
        zin[0] = 1'b1;
        vin[0] = in_valid;
`ifdef PIPE_ADDSUB_SAT_EN
        satin[0] = sat;
        sain[0]  = a[WIDTH-1];
`endif
        for (int unsigned k = 1; k < STAGES; k++) begin
            opa[k] = ska_q[k-1];
            opb[k] = skb_q[k-1];
            ci[k]  = c_q[k-1];
            rin[k] = res_q[k-1];
            zin[k] = z_q[k-1];
            vin[k] = v_q[k-1];
`ifdef PIPE_ADDSUB_SAT_EN
            satin[k] = sat_q[k-1];
            sain[k]  = sa_q[k-1];
`endif
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        cla_slice #(.SLICE(SLICE)) u_cla (
            .a     (opa[k][SLICE-1:0]),
            .b     (opb[k][SLICE-1:0]),
            .ci    (ci[k]),
            .s     (ss[k]),
            .co    (co[k]),
            .c_msb (cm[k])
        );
    end

    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            ska_d[k] = opa[k] >> SLICE;
            skb_d[k] = opb[k] >> SLICE;
            res_d[k] = rin[k];
            res_d[k][k*SLICE +: SLICE] = ss[k];
            c_d[k]   = co[k];
            z_d[k]   = zin[k] & ~|ss[k];
            v_d[k]   = vin[k];
`ifdef PIPE_ADDSUB_SAT_EN
            sat_d[k] = satin[k];
            sa_d[k]  = sain[k];
`endif
        end
        ovf_d = cm[L] ^ co[L];
`ifdef PIPE_ADDSUB_SAT_EN
        // Clamp direction follows operand A's sign; a clamped value is never zero.
        if (satin[L] && ovf_d) begin
            res_d[L] = sain[L] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            z_d[L]   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ska_q <= '0;
            skb_q <= '0;
            res_q <= '0;
            c_q   <= '0;
            z_q   <= '0;
            v_q   <= '0;
            ovf_q <= 1'b0;
`ifdef PIPE_ADDSUB_SAT_EN
            sat_q <= '0;
            sa_q  <= '0;
`endif
        end else if (adv) begin
            ska_q <= ska_d;
            skb_q <= skb_d;
            res_q <= res_d;
            c_q   <= c_d;
            z_q   <= z_d;
            v_q   <= v_d;
            ovf_q <= ovf_d;
`ifdef PIPE_ADDSUB_SAT_EN
            sat_q <= sat_d;
            sa_q  <= sa_d;
`endif
        end
    end

    assign adv       = !v_q[L] | out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[L];
    assign sum       = res_q[L];
    assign cout      = c_q[L];
    assign overflow  = ovf_q;
    assign zero      = z_q[L];
    assign neg       = res_q[L][WIDTH-1];

endmodule
